// File: rtl/us_sensor_scheduler.sv
// us_sensor_scheduler: 3-sensor ultrasonic trigger/echo scan FSM; define US_SCHED_FRONT_PRIORITY_EN to interleave sensor 0 between the others
module us_sensor_scheduler #(
  parameter int WARMUP_CYC = 50,
  parameter int TRIG_CYC   = 500,
  parameter int WINDOW_CYC = 50000,
  parameter int NEAR_CYC   = 29410
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic        en,
  input  logic [2:0]  mask,
  input  logic [2:0]  echo_rx,
  output logic [2:0]  trigger,
  output logic [15:0] dist_data,
  output logic [1:0]  dist_idx,
  output logic        dist_valid,
  output logic [2:0]  obstacle,
  output logic        busy,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    WARMUP = 3'd2,
    TRIG   = 3'd3,
    LISTEN = 3'd4,
    REPORT = 3'd5
  } state_t;
  localparam logic [15:0] WARM_END = 16'(WARMUP_CYC - 1);
  localparam logic [15:0] TRIG_END = 16'(TRIG_CYC - 1);
  localparam logic [15:0] WIN_END  = 16'(WINDOW_CYC - 1);
  localparam logic [15:0] NEAR     = 16'(NEAR_CYC);
  state_t      state_q, state_d;
  logic [2:0]  sync1_q, sync2_q;
  logic [15:0] cyc_q, cyc_d, cnt_q, cnt_d, dist_data_q, dist_data_d;
  logic [1:0]  sel_q, sel_d, dist_idx_q, dist_idx_d, nxt;
  logic [2:0]  trigger_q, trigger_d, obstacle_q, obstacle_d;
  logic        dist_valid_q, dist_valid_d, busy_q, busy_d, echo;
  assign echo = sync2_q[sel_q];
`ifdef US_SCHED_FRONT_PRIORITY_EN
  logic [1:0] rr_q, rr_d, f, s;
  assign f   = rr_q == 2'd1 ? 2'd2 : 2'd1;
  assign s   = rr_q == 2'd1 ? 2'd1 : 2'd2;
  assign nxt = (mask[0] && sel_q != 2'd0) ? 2'd0 : mask[f] ? f : mask[s] ? s : 2'd0;
  // remember the last non-front sensor so 1 and 2 alternate between visits to 0
  always_comb rr_d = (state_q == SELECT && en && mask != 3'b0 && nxt != 2'd0) ? nxt : rr_q;
  // front-priority rotation pointer
  always_ff @(posedge clk_50M) begin
    if (!reset) rr_q <= 2'd2;
    else rr_q <= rr_d;
  end
`else
  logic [1:0] a, b;
  assign a   = sel_q == 2'd2 ? 2'd0 : sel_q + 2'd1;
  assign b   = a == 2'd2 ? 2'd0 : a + 2'd1;
  assign nxt = mask[a] ? a : mask[b] ? b : sel_q;
`endif
  // next-state, counters and registered outputs for one measurement cycle
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q + 16'd1;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    dist_data_d = dist_data_q;
    dist_idx_d  = dist_idx_q;
    obstacle_d  = obstacle_q;
    case (state_q)
      IDLE:   state_d = (en && mask != 3'b0) ? SELECT : IDLE;
      SELECT: begin
        state_d = (!en || mask == 3'b0) ? IDLE : WARMUP;
        sel_d   = (!en || mask == 3'b0) ? sel_q : nxt;
        cyc_d   = 16'd0;
      end
      WARMUP: if (cyc_q == WARM_END) begin
        state_d = TRIG;
        cyc_d   = 16'd0;
      end
      TRIG: if (cyc_q == TRIG_END) begin
        state_d = LISTEN;
        cyc_d   = 16'd0;
        cnt_d   = 16'd0;
      end
      LISTEN: begin
        cnt_d = cnt_q + {15'd0, echo};
        if (cyc_q == WIN_END) begin
          state_d              = REPORT;
          dist_data_d          = echo ? 16'hFFFF : cnt_d;
          dist_idx_d           = sel_q;
          obstacle_d[sel_q]    = !echo && cnt_d != 16'd0 && cnt_d < NEAR;
        end
      end
      REPORT:  state_d = SELECT;
      default: state_d = IDLE;
    endcase
    trigger_d    = state_d == TRIG ? 3'b001 << sel_d : 3'b000;
    dist_valid_d = state_d == REPORT;
    busy_d       = state_d != IDLE;
  end
  // state, synchronizer and output registers; sel resets to 2 so sensor 0 is scanned first
  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      state_q      <= IDLE;
      sync1_q      <= 3'b0;
      sync2_q      <= 3'b0;
      cyc_q        <= 16'd0;
      cnt_q        <= 16'd0;
      sel_q        <= 2'd2;
      dist_data_q  <= 16'd0;
      dist_idx_q   <= 2'd0;
      obstacle_q   <= 3'b0;
      trigger_q    <= 3'b0;
      dist_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= echo_rx;
      sync2_q      <= sync1_q;
      cyc_q        <= cyc_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      dist_data_q  <= dist_data_d;
      dist_idx_q   <= dist_idx_d;
      obstacle_q   <= obstacle_d;
      trigger_q    <= trigger_d;
      dist_valid_q <= dist_valid_d;
      busy_q       <= busy_d;
    end
  end
  assign trigger    = trigger_q;
  assign dist_data  = dist_data_q;
  assign dist_idx   = dist_idx_q;
  assign dist_valid = dist_valid_q;
  assign obstacle   = obstacle_q;
  assign busy       = busy_q;
  assign state      = state_q;
endmodule

// File: tb/tb_us_sensor_scheduler.sv
// tb_us_sensor_scheduler: scoreboard bench for us_sensor_scheduler with shortened timing parameters
module tb_us_sensor_scheduler;
  localparam int W = 5, T = 8, L = 40, N = 20;
  logic        clk_50M = 1'b0, reset = 1'b0, en = 1'b0;
  logic [2:0]  mask = 3'b0, echo_rx = 3'b0;
  logic [2:0]  trigger, obstacle, state;
  logic [15:0] dist_data;
  logic [1:0]  dist_idx;
  logic        dist_valid, busy;
  int          checks = 0, errors = 0;
  logic [20:0] exp_q[$];
  logic        skip_run = 1'b0, trig1_seen = 1'b0;

  us_sensor_scheduler #(.WARMUP_CYC(W), .TRIG_CYC(T), .WINDOW_CYC(L), .NEAR_CYC(N)) dut (
    .clk_50M(clk_50M), .reset(reset), .en(en), .mask(mask), .echo_rx(echo_rx),
    .trigger(trigger), .dist_data(dist_data), .dist_idx(dist_idx), .dist_valid(dist_valid),
    .obstacle(obstacle), .busy(busy), .state(state)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout %s", name);
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    logic hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk_50M);
      hit = state == s;
    end
    if (!hit) timeout(name);
  endtask

  task automatic wait_strobe(input string name);
    logic hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk_50M);
      hit = dist_valid;
    end
    if (!hit) timeout(name);
  endtask

  task automatic measure(input int b, input int len);
    wait_state(3'd4, "listen");
    repeat (3) @(negedge clk_50M);
    echo_rx[b] = 1'b1;
    repeat (len) @(negedge clk_50M);
    echo_rx[b] = 1'b0;
    wait_strobe("measure");
  endtask

  // monitor: strobe scoreboard, trigger exclusivity, rise delay and pulse width
  initial begin
    int run = 0, age = 0;
    logic [2:0] prev = 3'b0;
    forever begin
      @(negedge clk_50M);
      if (dist_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe idx %0d data %0h obstacle %b", dist_idx, dist_data, obstacle);
        end else chk("strobe", {11'd0, dist_idx, dist_data, obstacle}, {11'd0, exp_q.pop_front()});
      end
      if ($countones(trigger) > 1) begin
        errors++;
        $display("FAIL trigger_onehot got %b expected at most one bit", trigger);
      end
      if (trigger[1]) trig1_seen = 1'b1;
      age = state == 3'd1 ? 0 : age + 1;
      if (trigger != 3'b0 && prev == 3'b0) chk("trig_rise", age, W + 1);
      if (trigger != 3'b0) run++;
      else begin
        if (run != 0 && !skip_run) chk("trig_len", run, T);
        run = 0;
      end
      prev = trigger;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_50M);
    chk("rst_state", state, 0);
    chk("rst_trigger", trigger, 0);
    chk("rst_valid", dist_valid, 0);
    chk("rst_data", dist_data, 0);
    chk("rst_idx", dist_idx, 0);
    chk("rst_obstacle", obstacle, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    @(negedge clk_50M);
    chk("idle_hold", state, 0);
`ifdef US_SCHED_FRONT_PRIORITY_EN
    exp_q.push_back({2'd0, 16'd0, 3'b000});
    exp_q.push_back({2'd1, 16'd0, 3'b000});
    exp_q.push_back({2'd0, 16'd0, 3'b000});
    exp_q.push_back({2'd2, 16'd0, 3'b000});
`else
    exp_q.push_back({2'd0, 16'd0, 3'b000});
    exp_q.push_back({2'd1, 16'd0, 3'b000});
    exp_q.push_back({2'd2, 16'd0, 3'b000});
    exp_q.push_back({2'd0, 16'd0, 3'b000});
`endif
    mask = 3'b111;
    en = 1'b1;
    repeat (4) wait_strobe("scan");
    en = 1'b0;
    wait_state(3'd0, "scan_idle");
    chk("scan_busy", busy, 0);
    mask = 3'b010;
    en = 1'b1;
    exp_q.push_back({2'd1, 16'd15, 3'b010});
    measure(1, 15);
    exp_q.push_back({2'd1, 16'd25, 3'b000});
    measure(1, 25);
    exp_q.push_back({2'd1, 16'd19, 3'b010});
    measure(1, 19);
    exp_q.push_back({2'd1, 16'd20, 3'b000});
    measure(1, 20);
    mask = 3'b100;
    exp_q.push_back({2'd2, 16'd10, 3'b100});
    measure(2, 10);
    echo_rx[2] = 1'b1;
    exp_q.push_back({2'd2, 16'hFFFF, 3'b000});
    wait_strobe("stuck");
    echo_rx[2] = 1'b0;
    mask = 3'b101;
    trig1_seen = 1'b0;
    exp_q.push_back({2'd0, 16'd0, 3'b000});
    exp_q.push_back({2'd2, 16'd0, 3'b000});
    exp_q.push_back({2'd0, 16'd0, 3'b000});
    repeat (5) @(negedge clk_50M);
    chk("hold_data", dist_data, 16'hFFFF);
    chk("hold_idx", dist_idx, 2);
    repeat (3) wait_strobe("mask");
    wait_state(3'd4, "drop_listen");
    en = 1'b0;
    exp_q.push_back({2'd2, 16'd0, 3'b000});
    wait_strobe("en_drop");
    repeat (3) @(negedge clk_50M);
    chk("drop_state", state, 0);
    chk("drop_busy", busy, 0);
    chk("mask_skip1", trig1_seen, 0);
    mask = 3'b010;
    en = 1'b1;
    wait_state(3'd3, "abort_trig");
    mask = 3'b111;
    repeat (3) @(negedge clk_50M);
    skip_run = 1'b1;
    reset = 1'b0;
    @(negedge clk_50M);
    reset = 1'b1;
    chk("abort_trigger", trigger, 0);
    chk("abort_state", state, 0);
    chk("abort_valid", dist_valid, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk_50M);
    skip_run = 1'b0;
    exp_q.push_back({2'd0, 16'd0, 3'b000});
    wait_strobe("post_reset");
    en = 1'b0;
    wait_state(3'd0, "final_idle");
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/us_sensor_scheduler.md
US_SENSOR_SCHEDULER -- requirements
Module: us_sensor_scheduler

Interface
REQ-001 Parameter WARMUP_CYC, default 50: idle cycles before each trigger.
REQ-002 Parameter TRIG_CYC, default 500: trigger high time in clocks (10 us at 50 MHz).
REQ-003 Parameter WINDOW_CYC, default 50000: echo listen window in clocks (1 ms).
REQ-004 Parameter NEAR_CYC, default 29410: obstacle flagged when echo count is nonzero and below this value.
REQ-005 Port clk_50M, input, 1: single 50 MHz clock; all logic SHALL be posedge clk_50M.
REQ-006 Port reset, input, 1: synchronous, active-low reset.
REQ-007 Port en, input, 1: scan enable.
REQ-008 Port mask, input, 3: per-sensor enable; bit i = 1 means sensor i is scanned.
REQ-009 Port echo_rx, input, 3: asynchronous echo lines, one per sensor.
REQ-010 Port trigger, output, 3: trigger lines, one per sensor; at most one bit high at any time.
REQ-011 Port dist_data, output, 16: echo-high count of the last completed measurement.
REQ-012 Port dist_idx, output, 2: sensor index for dist_data.
REQ-013 Port dist_valid, output, 1: one-cycle strobe qualifying dist_data and dist_idx.
REQ-014 Port obstacle, output, 3: registered per-sensor obstacle flags.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port state, output, 3: current FSM state encoding.

Function
REQ-017 Each echo_rx bit SHALL pass through a two-flop synchronizer; all counting SHALL use the synchronized value.
REQ-018 FSM states and encodings: IDLE=0, SELECT=1, WARMUP=2, TRIG=3, LISTEN=4, REPORT=5; encodings 6 and 7 SHALL return to IDLE on the next cycle.
REQ-019 IDLE: when en=1 and mask!=0, go to SELECT; otherwise remain in IDLE.
REQ-020 SELECT (1 cycle): choose the next unmasked sensor in scan order after the previous one and go to WARMUP; if mask=0 or en=0, go to IDLE.
REQ-021 WARMUP SHALL last exactly WARMUP_CYC cycles, with all trigger bits low.
REQ-022 TRIG: trigger[sel] SHALL be high for exactly TRIG_CYC consecutive cycles, then go to LISTEN.
REQ-023 LISTEN SHALL last exactly WINDOW_CYC cycles, incrementing a 16-bit counter on each cycle in which synchronized echo[sel]=1; the counter is cleared on entry.
REQ-024 REPORT (1 cycle): dist_valid=1, dist_idx=sel, dist_data=count; obstacle[sel] = (count!=0 && count<NEAR_CYC); the other obstacle bits SHALL hold.
REQ-025 Stuck echo: if synchronized echo[sel]=1 on the last LISTEN cycle, REPORT SHALL output dist_data=16'hFFFF and clear obstacle[sel].
REQ-026 After REPORT, go to SELECT.
REQ-027 Changes to mask or en in the middle of a measurement SHALL take effect only at the next SELECT; the current measurement always completes.
REQ-028 Sensor 0 SHALL be the first sensor scanned after reset.
REQ-029 dist_data and dist_idx SHALL hold their values between strobes.

Reset
REQ-030 When reset=0 at a clock edge: state=IDLE, trigger=0, dist_valid=0, dist_data=0, dist_idx=0, obstacle=0, busy=0, and all counters and synchronizers cleared, taking effect on that edge.
REQ-031 A reset in the middle of TRIG or LISTEN SHALL drop trigger at that edge, and no REPORT SHALL be issued for the aborted measurement.

Configuration
REQ-032 Macro US_SCHED_FRONT_PRIORITY_EN defined: the scan order interleaves sensor 0 between the others (0,1,0,2,0,1,...); if sensor 0 is masked, the order falls back to round-robin over the unmasked sensors.
REQ-033 Macro US_SCHED_FRONT_PRIORITY_EN undefined: plain round-robin order 0,1,2,0,..., skipping masked sensors.

Verification
REQ-034 Scan order: en=1, mask=3'b111, echo low -> dist_valid strobes with dist_idx 0,1,2,0 (1,2 slots interleaved with 0 when the macro is defined), dist_data=0, and obstacle=0.
REQ-035 Trigger timing: trigger[0] rises WARMUP_CYC+1 cycles after SELECT and is high for exactly 500 cycles; no two trigger bits are ever high together.
REQ-036 Near/far threshold: echo[1] high for 20000 cycles -> dist_data=20000 with obstacle[1]=1; high for 30000 cycles -> dist_data=30000 with obstacle[1]=0.
REQ-037 Stuck echo: echo[2] held high for the whole window -> dist_data=16'hFFFF, dist_idx=2, obstacle[2]=0.
REQ-038 Masking: mask=3'b101 -> sensor 1 is never triggered; en dropped during LISTEN -> that measurement is still reported, then IDLE with busy=0.
REQ-039 Reset abort: reset=0 for 1 cycle in the middle of TRIG -> trigger=0 at that edge, state=0, no dist_valid, and the next scan starts at sensor 0.
